// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: ALU opcodes, flag bit positions, default widths.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned NUM_FLAGS  = 5;

   // Flag register layout {C,L,F,Z,N}
   localparam int unsigned FLAG_C = 4;
   localparam int unsigned FLAG_L = 3;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 0;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_CMP = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_MOV = 4'd6,
      ALU_LSH = 4'd7,
      ALU_NOT = 4'd8
   } alu_op_e;

   // CMP computes flags only; its result must never reach the register file.
   function automatic logic op_writes_reg(input logic [3:0] op);
      return op != ALU_CMP;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result plus {C,L,F,Z,N} flags; reserved opcodes report no flag update.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [3:0]           op_i,
   input  logic [DATA_W-1:0]    a_i,
   input  logic [DATA_W-1:0]    b_i,
   output logic [DATA_W-1:0]    result_o,
   output logic [NUM_FLAGS-1:0] flags_o,
   output logic                 flags_valid_o
);

   alu_op_e         op;
   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;
   logic [3:0]      shamt;
   logic            lt_u;
   logic            lt_s;
   logic            ovf_add;
   logic            ovf_sub;
   logic            carry;
   logic            ovf;

   assign op    = alu_op_e'(op_i);
   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   // Top bit of the extended difference is the borrow.
   assign diff  = {1'b0, a_i} - {1'b0, b_i};
   assign shamt = b_i[3:0];
   assign lt_u  = a_i < b_i;
   assign lt_s  = $signed(a_i) < $signed(b_i);

   assign ovf_add = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
   assign ovf_sub = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);

   // Decode the opcode into a result and the arithmetic carry/overflow bits.
   always_comb begin
      result_o      = '0;
      carry         = 1'b0;
      ovf           = 1'b0;
      flags_valid_o = 1'b1;
      case (op)
         ALU_ADD: begin
            result_o = sum[DATA_W-1:0];
            carry    = sum[DATA_W];
            ovf      = ovf_add;
         end
         ALU_SUB, ALU_CMP: begin
            result_o = diff[DATA_W-1:0];
            carry    = diff[DATA_W];
            ovf      = ovf_sub;
         end
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_MOV: result_o = b_i;
         // b[4] picks the direction, b[3:0] the distance.
         ALU_LSH: result_o = b_i[4] ? (a_i >> shamt) : (a_i << shamt);
         ALU_NOT: result_o = ~a_i;
         default: flags_valid_o = 1'b0;
      endcase
   end

   // Pack the flag vector; compares are of the raw operands for every opcode.
   always_comb begin
      flags_o         = '0;
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_L] = lt_u;
      flags_o[FLAG_F] = ovf;
      flags_o[FLAG_Z] = (result_o == '0);
      flags_o[FLAG_N] = lt_s;
   end

endmodule

// File: rtl/cpu_datapath_pipe.sv
// CPU datapath: register file, forwarded operand reads, immediate mux, ALU, flags and
// a single EX/WB register through which every result (ALU or load) retires.
module cpu_datapath_pipe
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned SEL_W  = $clog2(NREGS),
   parameter int unsigned IMM_W  = 8,
   parameter int unsigned FLAG_W = NUM_FLAGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [SEL_W-1:0]  rd_a_sel,
   input  logic [SEL_W-1:0]  rd_b_sel,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic              wr_en,
   input  logic              use_imm,
   input  logic [IMM_W-1:0]  imm,
   input  logic              imm_sext,
   input  logic [3:0]        alu_op,
   input  logic              load_sel,
   input  logic [DATA_W-1:0] ext_data,
   input  logic              flag_en,
   output logic [DATA_W-1:0] bus_a,
   output logic [DATA_W-1:0] bus_b,
   output logic [DATA_W-1:0] result_q,
   output logic              result_valid,
   output logic [FLAG_W-1:0] flags_q
);

   localparam int unsigned EXT_W = DATA_W - IMM_W;

   logic [DATA_W-1:0]    regs_q [NREGS];
   logic                 valid_q;
   logic                 we_q;
   logic [SEL_W-1:0]     dest_q;

   logic                 wb_en;
   logic                 fwd_a;
   logic                 fwd_b;
   logic [DATA_W-1:0]    reg_b;
   logic                 ext_bit;
   logic [DATA_W-1:0]    imm_ext;
   logic [DATA_W-1:0]    alu_result;
   logic [NUM_FLAGS-1:0] alu_flags;
   logic                 alu_flags_valid;
   logic [DATA_W-1:0]    result_d;
   logic                 flag_upd;

   // A pending writeback commits on the same edge a new op may issue.
   assign wb_en = valid_q & we_q;

   // Forward the EX/WB value when it targets a register being read this cycle.
   assign fwd_a = wb_en && (dest_q == rd_a_sel);
   assign fwd_b = wb_en && (dest_q == rd_b_sel);
   assign bus_a = fwd_a ? result_q : regs_q[rd_a_sel];
   assign reg_b = fwd_b ? result_q : regs_q[rd_b_sel];

   assign ext_bit = imm_sext & imm[IMM_W-1];
   assign imm_ext = {{EXT_W{ext_bit}}, imm};
   assign bus_b   = use_imm ? imm_ext : reg_b;

   cpu_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i          (alu_op),
      .a_i           (bus_a),
      .b_i           (bus_b),
      .result_o      (alu_result),
      .flags_o       (alu_flags),
      .flags_valid_o (alu_flags_valid)
   );

   assign result_d     = load_sel ? ext_data : alu_result;
   assign flag_upd     = in_valid && flag_en && !load_sel && alu_flags_valid;
   assign result_valid = valid_q;

   // Register file: cleared on reset, written only from the EX/WB register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en) begin
         regs_q[dest_q] <= result_q;
      end
   end

   // EX/WB stage and flag register; reset drops any pending writeback.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q <= '0;
         valid_q  <= 1'b0;
         dest_q   <= '0;
         we_q     <= 1'b0;
         flags_q  <= '0;
      end else if (in_valid) begin
         result_q <= result_d;
         valid_q  <= 1'b1;
         dest_q   <= wr_sel;
         we_q     <= wr_en && op_writes_reg(alu_op);
         if (flag_upd) begin
            flags_q <= alu_flags;
         end
      end else begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_datapath_pipe.sv
// Bench for cpu_datapath_pipe: reset sweep, directed vector table, mid-op reset and a
// randomized run against an architectural model.
module tb_cpu_datapath_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [3:0]  rd_a_sel;
   logic [3:0]  rd_b_sel;
   logic [3:0]  wr_sel;
   logic        wr_en;
   logic        use_imm;
   logic [7:0]  imm;
   logic        imm_sext;
   logic [3:0]  alu_op;
   logic        load_sel;
   logic [15:0] ext_data;
   logic        flag_en;
   logic [15:0] bus_a;
   logic [15:0] bus_b;
   logic [15:0] result_q;
   logic        result_valid;
   logic [4:0]  flags_q;

   int n_cmp = 0;
   int n_bad = 0;

   cpu_datapath_pipe u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .rd_a_sel     (rd_a_sel),
      .rd_b_sel     (rd_b_sel),
      .wr_sel       (wr_sel),
      .wr_en        (wr_en),
      .use_imm      (use_imm),
      .imm          (imm),
      .imm_sext     (imm_sext),
      .alu_op       (alu_op),
      .load_sel     (load_sel),
      .ext_data     (ext_data),
      .flag_en      (flag_en),
      .bus_a        (bus_a),
      .bus_b        (bus_b),
      .result_q     (result_q),
      .result_valid (result_valid),
      .flags_q      (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  wr;
      logic        we;
      logic        ui;
      logic        sx;
      logic [7:0]  imm;
      logic        ld;
      logic [15:0] ext;
      logic        fe;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] eres;
      logic [4:0]  efl;
      logic        cres;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] wr, input logic we, input logic ui,
                               input logic sx, input logic [7:0] im, input logic ld,
                               input logic [15:0] ext, input logic fe, input logic [15:0] ea,
                               input logic [15:0] eb, input logic [15:0] eres,
                               input logic [4:0] efl, input logic cres);
      vec_t v;
      v.op = op; v.ra = ra; v.rb = rb; v.wr = wr; v.we = we; v.ui = ui; v.sx = sx;
      v.imm = im; v.ld = ld; v.ext = ext; v.fe = fe; v.ea = ea; v.eb = eb;
      v.eres = eres; v.efl = efl; v.cres = cres;
      return v;
   endfunction

   // Reference ALU from the arithmetic definitions; flags packed {C,L,F,Z,N}.
   function automatic void ref_alu(input int op, input int a, input int b, output int res,
                                   output logic [4:0] fl, output bit ok);
      int  sa;
      int  sb;
      int  t;
      int  sh;
      bit  c;
      bit  f;
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      c = 0; f = 0; ok = 1; res = 0;
      case (op)
         0: begin
            t = a + b; res = t % 65536; c = (t > 65535);
            f = (sa + sb > 32767) || (sa + sb < -32768);
         end
         1, 2: begin
            t = a - b; res = (t + 65536) % 65536; c = (a < b);
            f = (sa - sb > 32767) || (sa - sb < -32768);
         end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = b;
         7: begin
            sh = b % 16;
            if (((b / 16) % 2) == 1) res = a >> sh;
            else res = (a << sh) % 65536;
         end
         8: res = 65535 - a;
         default: ok = 0;
      endcase
      fl = {c, (a < b), f, (res == 0), (sa < sb)};
   endfunction

   task automatic idle_inputs();
      in_valid = 0; rd_a_sel = 0; rd_b_sel = 0; wr_sel = 0; wr_en = 0; use_imm = 0;
      imm = 0; imm_sext = 0; alu_op = 0; load_sel = 0; ext_data = 0; flag_en = 0;
   endtask

   task automatic rand_inputs();
      in_valid = ($urandom_range(0, 9) != 0);
      rd_a_sel = 4'($urandom_range(0, 15));
      rd_b_sel = 4'($urandom_range(0, 15));
      wr_sel   = 4'($urandom_range(0, 15));
      wr_en    = 1'($urandom_range(0, 1));
      use_imm  = 1'($urandom_range(0, 1));
      imm      = 8'($urandom);
      imm_sext = 1'($urandom_range(0, 1));
      alu_op   = 4'($urandom_range(0, 15));
      load_sel = ($urandom_range(0, 5) == 0);
      ext_data = 16'($urandom);
      flag_en  = 1'($urandom_range(0, 1));
   endtask

   vec_t vt [14];
   int   m_regs [16];
   int   m_res;
   bit   m_valid;
   bit   m_res_known;
   logic [4:0] m_flags;

   initial begin
      int ea, eb, r, immv;
      logic [4:0] fl;
      bit ok;

      vt[0]  = mk(4'd6, 4'd0,  4'd0, 4'd1,  1, 1, 0, 8'h7F, 0, 16'h0, 0,
                  16'h0000, 16'h007F, 16'h007F, 5'h00, 1);
      vt[1]  = mk(4'd0, 4'd1,  4'd1, 4'd2,  1, 0, 0, 8'h00, 0, 16'h0, 1,
                  16'h007F, 16'h007F, 16'h00FE, 5'h00, 1);
      vt[2]  = mk(4'd6, 4'd0,  4'd0, 4'd3,  1, 1, 1, 8'h80, 0, 16'h0, 0,
                  16'h0000, 16'hFF80, 16'hFF80, 5'h00, 1);
      vt[3]  = mk(4'd6, 4'd0,  4'd0, 4'd9,  1, 1, 1, 8'hFF, 0, 16'h0, 0,
                  16'h0000, 16'hFFFF, 16'hFFFF, 5'h00, 1);
      vt[4]  = mk(4'd7, 4'd9,  4'd0, 4'd10, 1, 1, 0, 8'h11, 0, 16'h0, 0,
                  16'hFFFF, 16'h0011, 16'h7FFF, 5'h00, 1);
      vt[5]  = mk(4'd0, 4'd10, 4'd0, 4'd11, 1, 1, 0, 8'h01, 0, 16'h0, 1,
                  16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1);
      vt[6]  = mk(4'd6, 4'd0,  4'd0, 4'd4,  1, 1, 0, 8'h05, 0, 16'h0, 0,
                  16'h0000, 16'h0005, 16'h0005, 5'h04, 1);
      vt[7]  = mk(4'd6, 4'd0,  4'd0, 4'd5,  1, 1, 0, 8'h09, 0, 16'h0, 0,
                  16'h0000, 16'h0009, 16'h0009, 5'h04, 1);
      vt[8]  = mk(4'd2, 4'd4,  4'd5, 4'd4,  1, 0, 0, 8'h00, 0, 16'h0, 1,
                  16'h0005, 16'h0009, 16'h0000, 5'h19, 0);
      vt[9]  = mk(4'd0, 4'd4,  4'd3, 4'd12, 0, 0, 0, 8'h00, 0, 16'h0, 0,
                  16'h0005, 16'hFF80, 16'hFF85, 5'h19, 1);
      vt[10] = mk(4'd0, 4'd0,  4'd0, 4'd6,  1, 0, 0, 8'h00, 1, 16'hBEEF, 1,
                  16'h0000, 16'h0000, 16'hBEEF, 5'h19, 1);
      vt[11] = mk(4'd5, 4'd6,  4'd6, 4'd7,  1, 0, 0, 8'h00, 0, 16'h0, 1,
                  16'hBEEF, 16'hBEEF, 16'h0000, 5'h02, 1);
      vt[12] = mk(4'd9, 4'd7,  4'd2, 4'd13, 1, 0, 0, 8'h00, 0, 16'h0, 1,
                  16'h0000, 16'h00FE, 16'h0000, 5'h02, 1);
      vt[13] = mk(4'd8, 4'd13, 4'd1, 4'd14, 1, 0, 0, 8'h00, 0, 16'h0, 1,
                  16'h0000, 16'h007F, 16'hFFFF, 5'h09, 1);

      // Reset held with random inputs: nothing may leave the cleared state.
      reset = 1'b0;
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rand_inputs();
         @(posedge clk);
         #1;
         chk("rst_valid", {31'b0, result_valid}, 32'd0);
         chk("rst_flags", {27'b0, flags_q}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         rd_a_sel = 4'(i);
         #1;
         chk("rst_reg", {16'b0, bus_a}, 32'd0);
      end
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;

      // Directed table: back-to-back issues, one row per cycle.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         in_valid = 1; alu_op = vt[i].op; rd_a_sel = vt[i].ra; rd_b_sel = vt[i].rb;
         wr_sel = vt[i].wr; wr_en = vt[i].we; use_imm = vt[i].ui; imm_sext = vt[i].sx;
         imm = vt[i].imm; load_sel = vt[i].ld; ext_data = vt[i].ext; flag_en = vt[i].fe;
         #1;
         chk($sformatf("vec%0d_bus_a", i), {16'b0, bus_a}, {16'b0, vt[i].ea});
         chk($sformatf("vec%0d_bus_b", i), {16'b0, bus_b}, {16'b0, vt[i].eb});
         @(posedge clk);
         #1;
         if (vt[i].cres) chk($sformatf("vec%0d_result", i), {16'b0, result_q}, {16'b0, vt[i].eres});
         chk($sformatf("vec%0d_valid", i), {31'b0, result_valid}, 32'd1);
         chk($sformatf("vec%0d_flags", i), {27'b0, flags_q}, {27'b0, vt[i].efl});
      end

      // Idle edge: valid drops, result and flags hold.
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
      chk("idle_valid", {31'b0, result_valid}, 32'd0);
      chk("idle_result", {16'b0, result_q}, 32'h0000FFFF);
      chk("idle_flags", {27'b0, flags_q}, 32'h09);

      // Mid-operation reset: ADD to r8 issued, reset lands before its writeback edge.
      @(negedge clk);
      in_valid = 1; alu_op = 4'd0; rd_a_sel = 4'd0; use_imm = 1; imm = 8'h33;
      wr_sel = 4'd8; wr_en = 1;
      @(posedge clk);
      #1;
      chk("midrst_issue", {16'b0, result_q}, 32'h33);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_valid", {31'b0, result_valid}, 32'd0);
      chk("midrst_result", {16'b0, result_q}, 32'd0);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rd_a_sel = 4'd8;
      #1;
      chk("midrst_r8", {16'b0, bus_a}, 32'd0);

      // Randomized run against the architectural model; writes are visible to the next op.
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      m_res = 0; m_valid = 0; m_res_known = 1; m_flags = 5'h00;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         rand_inputs();
         ea = m_regs[rd_a_sel];
         immv = int'(imm);
         if (imm_sext && imm >= 8'h80) immv = immv + 65280;
         eb = use_imm ? immv : m_regs[rd_b_sel];
         #1;
         chk("rnd_bus_a", {16'b0, bus_a}, 32'(ea));
         chk("rnd_bus_b", {16'b0, bus_b}, 32'(eb));
         if (in_valid) begin
            ref_alu(int'(alu_op), ea, eb, r, fl, ok);
            m_res = load_sel ? int'(ext_data) : r;
            m_valid = 1;
            m_res_known = load_sel || (alu_op != 4'd2);
            if (wr_en && alu_op != 4'd2) m_regs[wr_sel] = m_res;
            if (flag_en && !load_sel && ok) m_flags = fl;
         end else begin
            m_valid = 0;
         end
         @(posedge clk);
         #1;
         chk("rnd_valid", {31'b0, result_valid}, {31'b0, m_valid});
         chk("rnd_flags", {27'b0, flags_q}, {27'b0, m_flags});
         if (m_res_known) chk("rnd_result", {16'b0, result_q}, 32'(m_res));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_datapath_pipe.md
Name: cpu_datapath_pipe

Overview:
- Parametrised next-generation CPU datapath: register file, two operand read ports, immediate/register B-operand select, ALU, flag register, and a registered execute/writeback (EX/WB) stage with operand forwarding.
- Sits between the instruction decoder/controller and the memory load mux.
- All results, including load data, retire through one EX/WB register, so each register write takes effect exactly one cycle after issue.

Parameters:
- DATA_W, 16, datapath and register width.
- NREGS, 16, number of general registers; power of two, 2 or more.
- SEL_W, $clog2(NREGS), width of register selectors; derived.
- IMM_W, 8, immediate field width; must be less than DATA_W.
- FLAG_W, 5, flag register width; fixed at 5 ({C,L,F,Z,N}).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  issue strobe for the current operation.
- rd_a_sel  input  SEL_W  A-operand register.
- rd_b_sel  input  SEL_W  B-operand register.
- wr_sel  input  SEL_W  destination register.
- wr_en  input  1  operation writes its result to wr_sel.
- use_imm  input  1  1 selects the immediate as B-operand.
- imm  input  IMM_W  immediate field.
- imm_sext  input  1  1 sign-extends imm; 0 zero-extends it.
- alu_op  input  4  ALU operation code.
- load_sel  input  1  1 sends ext_data to EX/WB instead of ALU output.
- ext_data  input  DATA_W  load data from the memory mux.
- flag_en  input  1  1 updates the flag register on issue.
- bus_a  output  DATA_W  forwarded A-operand, combinational.
- bus_b  output  DATA_W  final B-operand after the immediate mux, combinational.
- result_q  output  DATA_W  EX/WB result register.
- result_valid  output  1  EX/WB valid bit.
- flags_q  output  FLAG_W  flag register {C,L,F,Z,N}.

Behaviour:
- Reset (asynchronous, while reset=0):
  - all NREGS registers, result_q and flags_q are cleared to 0;
  - result_valid=0 and the stored write enable is cleared to 0.
  - Reset mid-operation discards the pending writeback.
- Operand read and forwarding:
  - bus_a is the value of reg[rd_a_sel], except when result_valid=1, the stored write enable is 1 and the stored destination equals rd_a_sel; then bus_a=result_q.
  - The B-register read uses the same forwarding rule.
  - bus_b is the forwarded B-register value when use_imm=0, otherwise the extended imm.
- ALU, combinational; all arithmetic is modulo 2^DATA_W:
  - 0 ADD, a+b.
  - 1 SUB, a-b.
  - 2 CMP, a-b; flags only, result discarded.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MOV, b.
  - 7 LSH: shift a left by b[3:0] when b[4]=0, right logical by b[3:0] when b[4]=1.
  - 8 NOT, ~a.
  - 9-15 are reserved: result is 0 and flags are unchanged.
- Flags:
  - C = carry out of ADD, or borrow of SUB/CMP.
  - L = unsigned a<b.
  - F = signed overflow of ADD/SUB/CMP.
  - Z = result==0 (for CMP: a==b).
  - N = signed a<b.
  - C and F are 0 for logical ops.
- Issue edge (rising edge with in_valid=1):
  - result_q <= ext_data if load_sel=1, else the ALU result;
  - result_valid <= 1;
  - stored dest <= wr_sel;
  - stored write enable <= wr_en, except forced to 0 for CMP.
  - flags_q updates only if flag_en=1 and load_sel=0.
- Idle edge (in_valid=0): result_valid <= 0; result_q and flags_q hold.
- Writeback:
  - On every edge where result_valid=1 and the stored write enable is 1, reg[stored dest] <= result_q.
  - This is the same edge as a possible new issue. A back-to-back dependent op reads the forwarded value, so there is no stall and no hazard.
- Simultaneous events: writeback and a new issue to the same destination on one edge are legal. The new value lands in result_q and commits one edge later.
- Latency: issue to result_q is 1 cycle; issue to register file is 2 edges; issue to flags_q is 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - alu_op encodings ALU_ADD..ALU_NOT;
  - flag bit indices FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0;
  - default DATA_W.
- One natural sub-module: cpu_alu, combinational, parametrised by DATA_W, producing result and a flags vector.
- The register file, forwarding and EX/WB register stay in the top module.

Test Plan:
- Reset: hold reset=0 with random inputs -> result_valid=0 and flags_q=0; every register reads 0 via bus_a.
- Immediate load and add:
  - MOV imm 0x7F to r1 (use_imm=1, imm_sext=0) -> result_q=0x007F one cycle later.
  - Next cycle, ADD r1+r1 to r2 (forwarded) -> result_q=0x00FE and flags_q Z=0.
- Sign-extend and overflow:
  - MOV imm 0x80 with imm_sext=1 to r3 -> 0xFFFF… pattern 0xFF80.
  - ADD 0x7FFF+0x0001 with flag_en=1 -> result 0x8000, F=1, C=0, N-flag per signed compare.
- CMP: CMP r4=5 against r5=9 -> flags L=1, N=1, Z=0, C=1. Register file is unchanged and the stored write enable reads 0.
- Load and back-to-back hazard:
  - load_sel=1, ext_data=0xBEEF to r6;
  - next cycle XOR r6,r6 to r7 -> bus_a=0xBEEF (forwarded), result 0x0000, Z=1 when flag_en=1.
- Mid-operation reset: issue ADD to r8, then assert reset before the writeback edge -> r8 stays 0 and result_valid=0.
